instr_loader: RTL and testbench

Boot-time program loader: the writer side of the instruction memory that the fetch stage reads. It accepts a little-endian byte stream over a valid/ready handshake and decodes a 4-byte header (start address, word count). It assembles 16-bit instruction words and writes them sequentially into instruction memory through the memory's write port. `cpu_hold` is asserted for the whole load, so the pipeline does not fetch partially loaded code.

---
 rtl/instr_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader: byte stream with {addr, count} header into 16-bit instruction memory writes
// Optional trailing checksum verification is compiled in with LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO,
                             S_DATA_HI, S_CSUM_LO, S_CSUM_HI, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [3:0] {S_IDLE, S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO,
                             S_DATA_HI, S_DONE, S_ERR} state_t;
`endif

   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   state_t            state;
   logic [15:0]       start_addr;
   logic [7:0]        cnt_lo;
   logic [7:0]        lo_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       remain;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]       csum;
`endif

   logic [15:0] n_word;
   logic [16:0] end_sum;
   logic        range_bad;
   logic        xfer;

   assign n_word    = {in_data, cnt_lo};
   // 17-bit sum so a start address near the top cannot alias past the end of memory
   assign end_sum   = {1'b0, start_addr} + {1'b0, n_word};
   assign range_bad = end_sum > DEPTH;
   assign xfer      = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
   assign in_ready = (state inside {S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI,
                                    S_DATA_LO, S_DATA_HI, S_CSUM_LO, S_CSUM_HI});
`else
   assign in_ready = (state inside {S_ADDR_LO, S_ADDR_HI, S_CNT_LO, S_CNT_HI,
                                    S_DATA_LO, S_DATA_HI});
`endif
   assign cpu_hold = (state != S_IDLE) && (state != S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         start_addr   <= '0;
         cnt_lo       <= '0;
         lo_q         <= '0;
         addr_q       <= '0;
         remain       <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state        <= S_ADDR_LO;
                  err          <= 1'b0;
                  words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum         <= '0;
`endif
               end else if (state == S_DONE) begin
                  state <= S_IDLE;
               end
            end
            S_ADDR_LO: if (xfer) begin
               start_addr[7:0] <= in_data;
               state           <= S_ADDR_HI;
            end
            S_ADDR_HI: if (xfer) begin
               start_addr[15:8] <= in_data;
               state            <= S_CNT_LO;
            end
            S_CNT_LO: if (xfer) begin
               cnt_lo <= in_data;
               state  <= S_CNT_HI;
            end
            S_CNT_HI: if (xfer) begin
               if (range_bad) begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end else if (n_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= S_CSUM_LO;
`else
                  state <= S_DONE;
                  done  <= 1'b1;
`endif
               end else begin
                  state  <= S_DATA_LO;
                  addr_q <= start_addr[ADDR_W-1:0];
                  remain <= n_word;
               end
            end
            S_DATA_LO: if (xfer) begin
               lo_q  <= in_data;
               state <= S_DATA_HI;
            end
            S_DATA_HI: if (xfer) begin
               mem_we       <= 1'b1;
               mem_wdata    <= {in_data, lo_q};
               mem_addr     <= addr_q;
               addr_q       <= addr_q + ADDR_W'(1);
               remain       <= remain - 16'd1;
               words_loaded <= words_loaded + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
               csum         <= csum + {in_data, lo_q};
`endif
               if (remain == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= S_CSUM_LO;
`else
                  state <= S_DONE;
                  done  <= 1'b1;
`endif
               end else begin
                  state <= S_DATA_LO;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM_LO: if (xfer) begin
               lo_q  <= in_data;
               state <= S_CSUM_HI;
            end
            S_CSUM_HI: if (xfer) begin
               // words are already in memory; a mismatch only marks the image invalid
               if ({in_data, lo_q} == csum) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= S_ERR;
                  err   <= 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader against a queue-based load model
// Follows LOADER_CHECKSUM_EN when the design is built with it.
module tb_instr_loader;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   instr_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          obs_addr[$];
   int          obs_data[$];
   logic [15:0] words[$];
   logic        prev_xfer = 1'b0;
   bit          gaps = 1'b0;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   // every write must follow a byte transfer in the previous cycle
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         obs_addr.push_back(int'(mem_addr));
         obs_data.push_back(int'(mem_wdata));
         n_cmp++;
         assert (prev_xfer === 1'b1) else begin
            n_bad++;
            $error("FAIL we_without_xfer observed=%0b expected=1", prev_xfer);
         end
      end
      prev_xfer = in_valid && in_ready;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called at posedge+1; returns at posedge+1 just after the byte transferred
   task automatic send_byte(input logic [7:0] b);
      int guard;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      guard    = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 20) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      check("err_cleared", 32'(err), 32'd0);
      check("wl_cleared", 32'(words_loaded), 32'd0);
      tick();
   endtask

   // model: a range-legal load writes words[i] to a+i; success also needs a matching checksum
   task automatic run_load(input int a, input int n, input bit bad_csum);
      bit          range_ok;
      bit          ok;
      logic [15:0] sum;
      logic [15:0] w;
      obs_addr.delete();
      obs_data.delete();
      range_ok = (a + n) <= DEPTH;
      ok       = range_ok && !(CSUM && bad_csum);
      pulse_start();
      send_byte(8'(a));
      send_byte(8'(a >> 8));
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      if (!range_ok) begin
         @(negedge clk);
         check("range_err", 32'(err), 32'd1);
         check("range_done", 32'(done), 32'd0);
         check("range_hold", 32'(cpu_hold), 32'd1);
         check("range_ready", 32'(in_ready), 32'd0);
         repeat (3) tick();
         @(negedge clk);
         check("err_held_ready", 32'(in_ready), 32'd0);
         check("err_held_hold", 32'(cpu_hold), 32'd1);
         check("err_no_writes", 32'(obs_addr.size()), 32'd0);
         tick();
         return;
      end
      sum = 16'h0000;
      for (int i = 0; i < n; i++) begin
         w = words[i];
         send_byte(w[7:0]);
         send_byte(w[15:8]);
         sum = sum + w;
      end
      if (CSUM) begin
         if (bad_csum) sum = sum + 16'd1;
         send_byte(sum[7:0]);
         send_byte(sum[15:8]);
      end
      @(negedge clk);
      check("end_done", 32'(done), 32'(ok));
      check("end_err", 32'(err), 32'(!ok));
      check("end_hold", 32'(cpu_hold), 32'(!ok));
      check("end_wl", 32'(words_loaded), 32'(n));
      check("end_we", 32'(mem_we), 32'(!CSUM && n > 0));
      if (!CSUM && n > 0) check("end_addr", 32'(mem_addr), 32'(a + n - 1));
      tick();
      @(negedge clk);
      check("post_done", 32'(done), 32'd0);
      check("post_hold", 32'(cpu_hold), 32'(!ok));
      check("post_ready", 32'(in_ready), 32'd0);
      check("write_count", 32'(obs_addr.size()), 32'(n));
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
         check($sformatf("waddr%0d", i), 32'(obs_addr[i]), 32'(a + i));
         check($sformatf("wdata%0d", i), 32'(obs_data[i]), 32'(words[i]));
      end
      tick();
   endtask

   initial begin
      int a;
      int n;
      int lim;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_wl", 32'(words_loaded), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      words = '{16'h1234, 16'h5678, 16'h9ABC};
      run_load(32'h010, 3, 1'b0);
      gaps = 1'b1;
      run_load(32'h010, 3, 1'b0);
      gaps = 1'b0;
      if (CSUM) run_load(32'h010, 3, 1'b1);

      run_load(32'h0FFE, 3, 1'b0);
      words = '{16'hBEEF};
      run_load(32'h0FFF, 1, 1'b0);
      run_load(32'h020, 0, 1'b0);

      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
      check("mid_rst_hold", 32'(cpu_hold), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_wl", 32'(words_loaded), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      words = '{16'hA5A5, 16'h0F0F, 16'h1357, 16'hFFFF};
      run_load(32'h100, 4, 1'b0);

      for (int k = 0; k < 10; k++) begin
         a = $urandom_range(0, DEPTH - 1);
         if ($urandom_range(0, 4) == 0) begin
            n = DEPTH - a + 1 + $urandom_range(0, 3);
         end else begin
            lim = (DEPTH - a < 6) ? DEPTH - a : 6;
            n   = $urandom_range(0, lim);
         end
         words.delete();
         for (int i = 0; i < 6; i++) words.push_back(16'($urandom));
         gaps = 1'($urandom_range(0, 1));
         run_load(a, n, 1'($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
